// File: rtl/sdrc_sdr_resp.sv
// sdrc_sdr_resp: device side of the 16-bit SDR SDRAM bus, backed by a small array.
// Define SDRC_RESP_CHECK_EN to build the protocol checker and tRCD/tRP counters.
module sdrc_sdr_resp #(
    parameter int MEM_ROWB = 2,
    parameter int MEM_COLB = 4,
    parameter int TRCD     = 2,
    parameter int TRP      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdr_cke,
    input  logic        sdr_cs_n,
    input  logic        sdr_ras_n,
    input  logic        sdr_cas_n,
    input  logic        sdr_we_n,
    input  logic [1:0]  sdr_ba,
    input  logic [12:0] sdr_addr,
    input  logic [1:0]  sdr_dqm,
    input  logic [15:0] sdr_dout,
    input  logic [1:0]  sdr_den_n,
    output logic [15:0] sdr_din,
    output logic [12:0] resp_mode_reg,
    output logic        resp_mrs_done,
    output logic        resp_rd_busy,
    output logic [2:0]  resp_err
);
    localparam int AW    = 2 + MEM_ROWB + MEM_COLB;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;
    state_t state, state_nxt;

    logic [15:0] mem [DEPTH];

    logic       cmd_en;
    logic [2:0] cmd;
    logic       cmd_mrs, cmd_ref, cmd_pre, cmd_act;
    logic       cmd_wr, cmd_rd, cmd_bst;

    assign cmd_en  = sdr_cke & ~sdr_cs_n;
    assign cmd     = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign cmd_mrs = cmd_en && cmd == 3'b000;
    assign cmd_ref = cmd_en && cmd == 3'b001;
    assign cmd_pre = cmd_en && cmd == 3'b010;
    assign cmd_act = cmd_en && cmd == 3'b011;
    assign cmd_wr  = cmd_en && cmd == 3'b100;
    assign cmd_rd  = cmd_en && cmd == 3'b101;
    assign cmd_bst = cmd_en && cmd == 3'b110;

    logic [12:0] mode_reg;
    logic [1:0]  bl_code;
    logic        cl3;
    logic        mrs_done;
    logic        bl_ok, cl_ok;
    logic [3:0]  bl_len;
    logic [MEM_COLB-1:0] col_mask;

    assign bl_ok    = ~sdr_addr[2];
    assign cl_ok    = sdr_addr[6:5] == 2'b01;
    assign bl_len   = 4'd1 << bl_code;
    assign col_mask = MEM_COLB'(bl_len - 4'd1);

    logic [3:0]                 bank_act;
    logic [3:0][MEM_ROWB-1:0]   bank_row;

    logic [1:0]          b_ba;
    logic [MEM_ROWB-1:0] b_row;
    logic [MEM_COLB-1:0] b_col;
    logic [3:0]          b_rem;
    logic                b_ap;

    logic                term;
    logic                beat_v, beat_wr, beat_last, beat_ap;
    logic [1:0]          beat_ba;
    logic [MEM_ROWB-1:0] beat_row;
    logic [MEM_COLB-1:0] beat_col;
    logic [AW-1:0]       idx;
    logic                we, rd;
    logic [15:0]         rd_data;

    // Sequential column order wrapping inside the BL-aligned block.
    function automatic logic [MEM_COLB-1:0] col_adv(
        input logic [MEM_COLB-1:0] c,
        input logic [MEM_COLB-1:0] m
    );
        return (c & ~m) | ((c + MEM_COLB'(1)) & m);
    endfunction

    always_comb begin
        term      = cmd_rd | cmd_wr | cmd_bst |
                    (cmd_pre & (sdr_addr[10] | (sdr_ba == b_ba)));
        beat_v    = 1'b0;
        beat_wr   = 1'b0;
        beat_ba   = b_ba;
        beat_row  = b_row;
        beat_col  = b_col;
        beat_last = (b_rem == 4'd1);
        beat_ap   = b_ap;
        state_nxt = state;
        if (cmd_rd | cmd_wr) begin
            beat_v    = 1'b1;
            beat_wr   = cmd_wr;
            beat_ba   = sdr_ba;
            beat_row  = bank_row[sdr_ba];
            beat_col  = sdr_addr[MEM_COLB-1:0];
            beat_last = (bl_len == 4'd1);
            beat_ap   = sdr_addr[10];
            state_nxt = beat_last ? ST_IDLE : (cmd_wr ? ST_WRITE : ST_READ);
        end else if (state != ST_IDLE) begin
            if (term) begin
                state_nxt = ST_IDLE;
            end else begin
                beat_v  = 1'b1;
                beat_wr = (state == ST_WRITE);
                if (beat_last) state_nxt = ST_IDLE;
            end
        end
    end

    assign idx     = {beat_ba, beat_row, beat_col};
    assign we      = beat_v & beat_wr;
    assign rd      = beat_v & ~beat_wr;
    assign rd_data = mem[idx];

    always_ff @(posedge clk) begin
        if (we && !sdr_dqm[0]) mem[idx][7:0]  <= sdr_dout[7:0];
        if (we && !sdr_dqm[1]) mem[idx][15:8] <= sdr_dout[15:8];
    end

    logic [1:0]  dqm_d;
    logic        p0_v, p1_v, busy;
    logic [15:0] p0_d, p1_d, din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            b_ba     <= '0;
            b_row    <= '0;
            b_col    <= '0;
            b_rem    <= '0;
            b_ap     <= 1'b0;
            mode_reg <= 13'h033;
            bl_code  <= 2'b11;
            cl3      <= 1'b1;
            mrs_done <= 1'b0;
            bank_act <= '0;
            bank_row <= '0;
            dqm_d    <= '0;
            p0_v     <= 1'b0;
            p0_d     <= '0;
            p1_v     <= 1'b0;
            p1_d     <= '0;
            busy     <= 1'b0;
            din      <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_rd | cmd_wr) begin
                b_ba  <= sdr_ba;
                b_row <= bank_row[sdr_ba];
                b_col <= col_adv(sdr_addr[MEM_COLB-1:0], col_mask);
                b_rem <= bl_len - 4'd1;
                b_ap  <= sdr_addr[10];
            end else if (beat_v) begin
                b_col <= col_adv(b_col, col_mask);
                b_rem <= b_rem - 4'd1;
            end
            if (cmd_mrs) begin
                mode_reg <= sdr_addr;
                mrs_done <= 1'b1;
                if (bl_ok) bl_code <= sdr_addr[1:0];
                if (cl_ok) cl3 <= sdr_addr[4];
            end
            if (beat_v & beat_last & beat_ap) bank_act[beat_ba] <= 1'b0;
            if (cmd_pre) begin
                if (sdr_addr[10]) bank_act <= '0;
                else bank_act[sdr_ba] <= 1'b0;
            end
            if (cmd_act) begin
                bank_act[sdr_ba] <= 1'b1;
                bank_row[sdr_ba] <= sdr_addr[MEM_ROWB-1:0];
            end
            // CL3 enters at stage 0, CL2 skips straight to stage 1.
            dqm_d <= sdr_dqm;
            p0_v  <= rd & cl3;
            p0_d  <= rd_data;
            p1_v  <= (rd & ~cl3) | p0_v;
            p1_d  <= (rd & ~cl3) ? rd_data : p0_d;
            busy  <= p1_v;
            din   <= p1_v ? {dqm_d[1] ? 8'h00 : p1_d[15:8],
                             dqm_d[0] ? 8'h00 : p1_d[7:0]} : 16'h0000;
        end
    end

    assign sdr_din       = din;
    assign resp_rd_busy  = busy;
    assign resp_mode_reg = mode_reg;
    assign resp_mrs_done = mrs_done;

`ifdef SDRC_RESP_CHECK_EN
    logic [3:0][3:0] trcd_cnt;
    logic [3:0][3:0] trp_cnt;
    logic [2:0]      err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trcd_cnt <= '0;
            trp_cnt  <= '0;
            err      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (trcd_cnt[i] != 4'd0) trcd_cnt[i] <= trcd_cnt[i] - 4'd1;
                if (trp_cnt[i] != 4'd0) trp_cnt[i] <= trp_cnt[i] - 4'd1;
                if (cmd_pre && (sdr_addr[10] || sdr_ba == 2'(i)))
                    trp_cnt[i] <= 4'(TRP - 1);
            end
            if (beat_v & beat_last & beat_ap) trp_cnt[beat_ba] <= 4'(TRP - 1);
            if (cmd_act) trcd_cnt[sdr_ba] <= 4'(TRCD - 1);
            if ((cmd_act & bank_act[sdr_ba]) |
                ((cmd_rd | cmd_wr) & ~bank_act[sdr_ba]) |
                (cmd_ref & (|bank_act)) |
                (we & (|sdr_den_n)))
                err[0] <= 1'b1;
            if (cmd_mrs & ~(bl_ok & cl_ok)) err[1] <= 1'b1;
            if (((cmd_rd | cmd_wr) && trcd_cnt[sdr_ba] != 4'd0) ||
                (cmd_act && trp_cnt[sdr_ba] != 4'd0))
                err[2] <= 1'b1;
        end
    end

    assign resp_err = err;
`else
    logic unused_chk;
    assign unused_chk = &{1'b0, sdr_den_n, cmd_ref, 4'(TRCD), 4'(TRP)};
    assign resp_err   = 3'b000;
`endif

endmodule

// File: tb/tb_sdrc_sdr_resp.sv
// tb_sdrc_sdr_resp: scoreboard bench for the SDR SDRAM responder.
// Read beats are queued with their due cycle at issue and retired off sdr_din.
module tb_sdrc_sdr_resp;
    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_NOP = 3'b111;

`ifdef SDRC_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sdr_cke = 1'b1;
    logic        sdr_cs_n = 1'b0;
    logic        sdr_ras_n = 1'b1;
    logic        sdr_cas_n = 1'b1;
    logic        sdr_we_n = 1'b1;
    logic [1:0]  sdr_ba = '0;
    logic [12:0] sdr_addr = '0;
    logic [1:0]  sdr_dqm = '0;
    logic [15:0] sdr_dout = '0;
    logic [1:0]  sdr_den_n = '0;
    logic [15:0] sdr_din;
    logic [12:0] resp_mode_reg;
    logic        resp_mrs_done;
    logic        resp_rd_busy;
    logic [2:0]  resp_err;

    sdrc_sdr_resp dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sdr_cke       (sdr_cke),
        .sdr_cs_n      (sdr_cs_n),
        .sdr_ras_n     (sdr_ras_n),
        .sdr_cas_n     (sdr_cas_n),
        .sdr_we_n      (sdr_we_n),
        .sdr_ba        (sdr_ba),
        .sdr_addr      (sdr_addr),
        .sdr_dqm       (sdr_dqm),
        .sdr_dout      (sdr_dout),
        .sdr_den_n     (sdr_den_n),
        .sdr_din       (sdr_din),
        .resp_mode_reg (resp_mode_reg),
        .resp_mrs_done (resp_mrs_done),
        .resp_rd_busy  (resp_rd_busy),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] ref_mem [256];
    int          edge_n = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        beat_t e;
        if (reset_n) begin
            if (resp_rd_busy) begin
                if (exp_q.size() == 0) begin
                    check("rd_busy_extra", 32'(resp_rd_busy), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(sdr_din), 32'(e.d));
                    check("rd_cycle", edge_n, e.cyc);
                end
            end else begin
                check("idle_din", 32'(sdr_din), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
                    void'(exp_q.pop_front());
                    check("rd_busy_missing", 32'(resp_rd_busy), 32'd1);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] c, input logic [1:0] ba,
                         input logic [12:0] a, input logic [1:0] dqm,
                         input logic [15:0] d);
        {sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
        sdr_ba   = ba;
        sdr_addr = a;
        sdr_dqm  = dqm;
        sdr_dout = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    function automatic int idx(input int ba, input int row, input int col);
        return ba * 64 + (row % 4) * 16 + (col % 16);
    endfunction

    function automatic int colk(input int c, input int bl, input int k);
        return (c & ~(bl - 1)) | ((c + k) & (bl - 1));
    endfunction

    task automatic wr_burst(input int ba, input int row, input int col,
                            input int bl, input logic [15:0] base,
                            input int mbeat, input logic [1:0] mval);
        for (int k = 0; k < bl; k++) begin
            int          c;
            logic [1:0]  m;
            logic [15:0] dd;
            c  = colk(col, bl, k);
            m  = (k == mbeat) ? mval : 2'b00;
            dd = base + 16'(k);
            if (!m[0]) ref_mem[idx(ba, row, c)][7:0] = dd[7:0];
            if (!m[1]) ref_mem[idx(ba, row, c)][15:8] = dd[15:8];
            drive(k == 0 ? C_WR : C_NOP, 2'(ba), k == 0 ? 13'(col) : 13'd0, m, dd);
        end
    endtask

    task automatic rd_burst(input int ba, input int row, input int col,
                            input int bl, input int cl, input int nb);
        int t;
        t = edge_n + 1;
        for (int k = 0; k < nb; k++)
            exp_q.push_back(beat_t'{t + cl - 1 + k,
                                    ref_mem[idx(ba, row, colk(col, bl, k))]});
        drive(C_RD, 2'(ba), 13'(col), 2'b00, 16'h0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) nops(1);
        check("drain", 32'(exp_q.size()), 32'd0);
        nops(1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_din", 32'(sdr_din), 32'd0);
        check("rst_mode", 32'(resp_mode_reg), 32'h033);
        check("rst_mrs_done", 32'(resp_mrs_done), 32'd0);
        check("rst_busy", 32'(resp_rd_busy), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        reset_n = 1'b1;

        drive(C_MRS, 2'd0, 13'h023, 2'b00, 16'h0);
        check("mrs_mode", 32'(resp_mode_reg), 32'h023);
        check("mrs_done", 32'(resp_mrs_done), 32'd1);
        check("mrs_err", 32'(resp_err), 32'd0);
        nops(2);

        drive(C_ACT, 2'd1, 13'd3, 2'b00, 16'h0);
        nops(1);
        wr_burst(1, 3, 0, 8, 16'h1000, -1, 2'b00);
        check("wr_err", 32'(resp_err), 32'd0);
        rd_burst(1, 3, 0, 8, 2, 8);
        wait_drain();

        drive(C_MRS, 2'd0, 13'h022, 2'b00, 16'h0);
        wr_burst(1, 3, 5, 4, 16'h2000, 1, 2'b10);
        rd_burst(1, 3, 5, 4, 2, 4);
        wait_drain();

        drive(C_MRS, 2'd0, 13'h033, 2'b00, 16'h0);
        rd_burst(1, 3, 0, 8, 3, 3);
        nops(2);
        rd_burst(1, 3, 2, 8, 3, 8);
        wait_drain();

        drive(C_ACT, 2'd1, 13'd3, 2'b00, 16'h0);
        check("err_act_active", 32'(resp_err), CHK ? 32'd1 : 32'd0);
        drive(C_MRS, 2'd0, 13'h007, 2'b00, 16'h0);
        check("err_bad_mrs", 32'(resp_err), CHK ? 32'd3 : 32'd0);
        check("mode_bad_mrs", 32'(resp_mode_reg), 32'h007);
        rd_burst(1, 3, 0, 8, 3, 8);
        wait_drain();

        drive(C_PRE, 2'd1, 13'd0, 2'b00, 16'h0);
        nops(1);
        drive(C_ACT, 2'd1, 13'd3, 2'b00, 16'h0);
        check("err_trp_ok", 32'(resp_err), CHK ? 32'd3 : 32'd0);
        drive(C_WR, 2'd1, 13'd0, 2'b11, 16'hffff);
        drive(C_BST, 2'd0, 13'd0, 2'b00, 16'h0);
        check("err_trcd", 32'(resp_err), CHK ? 32'd7 : 32'd0);
        nops(2);

        rd_burst(1, 3, 0, 8, 3, 8);
        nops(1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_din", 32'(sdr_din), 32'd0);
        check("mid_rst_busy", 32'(resp_rd_busy), 32'd0);
        check("mid_rst_err", 32'(resp_err), 32'd0);
        check("mid_rst_mode", 32'(resp_mode_reg), 32'h033);
        check("mid_rst_mrs", 32'(resp_mrs_done), 32'd0);
        nops(2);
        reset_n = 1'b1;
        nops(4);

        drive(C_WR, 2'd1, 13'd0, 2'b11, 16'h0);
        drive(C_BST, 2'd0, 13'd0, 2'b00, 16'h0);
        check("err_wr_idle", 32'(resp_err), CHK ? 32'd1 : 32'd0);
        nops(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

endmodule
